accumulate_multi: RTL and testbench

ACCUMULATE_MULTI -- requirements
Module: accumulate_multi

---
 rtl/accumulate_multi.sv | 99 +++++++++
 tb/tb_accumulate_multi.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulate_multi.sv
// rtl/accumulate_multi.sv - multi-channel signed frame accumulator with per-channel sticky overflow
module accumulate_multi #(
    parameter int ARGW = 32,
    parameter int RESW = 40,
    parameter int CHNW = 2,
    parameter int SAT  = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   arg_stb,
    input  logic signed [ARGW-1:0] arg_dat,
    input  logic        [CHNW-1:0] arg_chn,
    input  logic                   arg_lst,
    output logic                   arg_rdy,
    output logic                   res_stb,
    output logic signed [RESW-1:0] res_dat,
    output logic        [CHNW-1:0] res_chn,
    output logic                   res_ovf,
    input  logic                   res_rdy
);

    localparam int NCH = 2 ** CHNW;
    localparam logic signed [RESW-1:0] SUM_MAX = {1'b0, {(RESW-1){1'b1}}};
    localparam logic signed [RESW-1:0] SUM_MIN = {1'b1, {(RESW-1){1'b0}}};

    generate
        if (RESW < ARGW) begin : g_param_check
            $error("accumulate_multi: RESW (%0d) must be >= ARGW (%0d)", RESW, ARGW);
        end
    endgenerate

    logic signed [RESW-1:0] acc [NCH];
    logic        [NCH-1:0]  ovf;

    logic                   accept;
    logic signed [RESW-1:0] addend;
    logic signed [RESW-1:0] cur;
    logic signed [RESW-1:0] raw_sum;
    logic signed [RESW-1:0] new_sum;
    logic                   ovf_now;
    logic                   new_flag;

    // A beat may only land when the result slot is free or being drained this edge.
    assign arg_rdy = ~clr & (~res_stb | res_rdy);
    assign accept  = arg_stb & arg_rdy;

    always_comb begin
        addend   = RESW'(arg_dat);
        cur      = acc[arg_chn];
        raw_sum  = cur + addend;
        ovf_now  = (cur[RESW-1] == addend[RESW-1]) && (raw_sum[RESW-1] != cur[RESW-1]);
        new_sum  = raw_sum;
        if ((SAT != 0) && ovf_now) begin
            new_sum = cur[RESW-1] ? SUM_MIN : SUM_MAX;
        end
        new_flag = ovf[arg_chn] | ovf_now;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                acc[i] <= '0;
            end
            ovf <= '0;
        end else if (clr) begin
            for (int i = 0; i < NCH; i++) begin
                acc[i] <= '0;
            end
            ovf <= '0;
        end else if (accept) begin
            // A completed frame restarts its channel from zero.
            if (arg_lst) begin
                acc[arg_chn] <= '0;
                ovf[arg_chn] <= 1'b0;
            end else begin
                acc[arg_chn] <= new_sum;
                ovf[arg_chn] <= new_flag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_stb <= 1'b0;
            res_dat <= '0;
            res_chn <= '0;
            res_ovf <= 1'b0;
        end else if (accept && arg_lst) begin
            res_stb <= 1'b1;
            res_dat <= new_sum;
            res_chn <= arg_chn;
            res_ovf <= new_flag;
        end else if (res_rdy) begin
            res_stb <= 1'b0;
        end
    end

endmodule

// File: tb/tb_accumulate_multi.sv
// tb/tb_accumulate_multi.sv - randomized and directed checks of accumulate_multi against an integer model
module tb_accumulate_multi;

    logic              clk;
    logic              rst_n;
    logic              clr;
    logic              arg_stb;
    logic signed [7:0] arg_dat;
    logic        [1:0] arg_chn;
    logic              arg_lst;
    logic              res_rdy;

    logic              arg_rdy_w, arg_rdy_s;
    logic              res_stb_w, res_stb_s;
    logic signed [9:0] res_dat_w, res_dat_s;
    logic        [1:0] res_chn_w, res_chn_s;
    logic              res_ovf_w, res_ovf_s;

    accumulate_multi #(.ARGW(8), .RESW(10), .CHNW(2), .SAT(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .arg_stb(arg_stb), .arg_dat(arg_dat), .arg_chn(arg_chn), .arg_lst(arg_lst), .arg_rdy(arg_rdy_w),
        .res_stb(res_stb_w), .res_dat(res_dat_w), .res_chn(res_chn_w), .res_ovf(res_ovf_w), .res_rdy(res_rdy)
    );

    accumulate_multi #(.ARGW(8), .RESW(10), .CHNW(2), .SAT(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .arg_stb(arg_stb), .arg_dat(arg_dat), .arg_chn(arg_chn), .arg_lst(arg_lst), .arg_rdy(arg_rdy_s),
        .res_stb(res_stb_s), .res_dat(res_dat_s), .res_chn(res_chn_s), .res_ovf(res_ovf_s), .res_rdy(res_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int chn;
        int dw;
        int ds;
        bit ow;
        bit os;
    } res_t;

    res_t q[$];
    int   sw[4];
    int   ss[4];
    bit   fw[4];
    bit   fs[4];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            sw[i] = 0; ss[i] = 0; fw[i] = 0; fs[i] = 0;
        end
    endtask

    // One clock cycle: inputs are already set just after a falling edge.
    task automatic tick(output bit accepted);
        bit   exp_stb, exp_rdy;
        res_t r;
        int   c, d, rw, rs;
        #1;
        exp_stb = (q.size() != 0);
        exp_rdy = !clr && (!exp_stb || res_rdy);
        check("arg_rdy_wrap", arg_rdy_w, exp_rdy);
        check("arg_rdy_sat", arg_rdy_s, exp_rdy);
        check("res_stb_wrap", res_stb_w, exp_stb);
        check("res_stb_sat", res_stb_s, exp_stb);
        if (exp_stb) begin
            r = q[0];
            check("res_chn_wrap", int'(res_chn_w), r.chn);
            check("res_chn_sat", int'(res_chn_s), r.chn);
            check("res_dat_wrap", res_dat_w, r.dw);
            check("res_dat_sat", res_dat_s, r.ds);
            check("res_ovf_wrap", res_ovf_w, r.ow);
            check("res_ovf_sat", res_ovf_s, r.os);
        end
        accepted = arg_stb && exp_rdy;
        if (exp_stb && res_rdy) void'(q.pop_front());
        if (clr) begin
            model_clear();
        end else if (accepted) begin
            c  = int'(arg_chn);
            d  = int'(arg_dat);
            rw = sw[c] + d;
            rs = ss[c] + d;
            if (rw > 511 || rw < -512) begin
                fw[c] = 1;
                rw = ((rw + 512 + 1024) % 1024) - 512;
            end
            if (rs > 511)  begin fs[c] = 1; rs = 511;  end
            if (rs < -512) begin fs[c] = 1; rs = -512; end
            if (arg_lst) begin
                r.chn = c; r.dw = rw; r.ds = rs; r.ow = fw[c]; r.os = fs[c];
                q.push_back(r);
                sw[c] = 0; ss[c] = 0; fw[c] = 0; fs[c] = 0;
            end else begin
                sw[c] = rw; ss[c] = rs;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input int c, input int d, input bit l);
        bit a;
        a = 0;
        arg_stb = 1'b1;
        arg_chn = 2'(c);
        arg_dat = 8'(d);
        arg_lst = l;
        for (int k = 0; k < 20 && !a; k++) tick(a);
        check("send_accepted", a, 1);
        arg_stb = 1'b0;
        arg_lst = 1'b0;
    endtask

    task automatic drain();
        bit a;
        arg_stb = 1'b0;
        res_rdy = 1'b1;
        repeat (3) tick(a);
    endtask

    initial begin
        bit a;
        rst_n = 1'b0; clr = 1'b0; arg_stb = 1'b0; arg_dat = '0; arg_chn = '0; arg_lst = 1'b0; res_rdy = 1'b1;
        model_clear();
        #2;
        check("rst_res_stb", res_stb_w, 0);
        check("rst_res_dat", res_dat_w, 0);
        check("rst_res_chn", int'(res_chn_s), 0);
        check("rst_res_ovf", res_ovf_s, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Three-beat frame on channel 0
        send(0, 3, 0); send(0, -5, 0); send(0, 7, 1);
        check("r032_stb", res_stb_w, 1);
        check("r032_dat", res_dat_w, 5);
        check("r032_chn", int'(res_chn_w), 0);
        check("r032_ovf", res_ovf_w, 0);
        drain();

        // Interleaved channels complete in acceptance order
        send(1, 100, 0);
        send(2, -1, 1);
        check("r033_first_chn", int'(res_chn_w), 2);
        check("r033_first_dat", res_dat_w, -1);
        send(1, 20, 1);
        check("r033_second_chn", int'(res_chn_w), 1);
        check("r033_second_dat", res_dat_w, 120);
        drain();

        // Overflow: wrap vs saturate
        for (int i = 0; i < 5; i++) send(3, 127, i == 4);
        check("r034_wrap_dat", res_dat_w, -389);
        check("r034_wrap_ovf", res_ovf_w, 1);
        check("r034_sat_dat", res_dat_s, 511);
        check("r034_sat_ovf", res_ovf_s, 1);
        drain();

        // Backpressure then back-to-back results
        res_rdy = 1'b0;
        send(0, 1, 1);
        arg_stb = 1'b1; arg_chn = 2'd1; arg_dat = 8'sd2; arg_lst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(a);
            check("r035_stall_no_accept", a, 0);
        end
        res_rdy = 1'b1;
        tick(a);
        check("r035_accept", a, 1);
        arg_stb = 1'b0; arg_lst = 1'b0;
        check("r035_bb_stb", res_stb_w, 1);
        check("r035_bb_dat", res_dat_w, 2);
        drain();

        // Asynchronous reset mid-frame with a pending result
        res_rdy = 1'b0;
        send(0, 10, 0); send(0, 20, 0); send(2, 9, 1);
        check("r036_pending", res_stb_w, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("r036_rst_stb_wrap", res_stb_w, 0);
        check("r036_rst_stb_sat", res_stb_s, 0);
        check("r036_rst_dat", res_dat_w, 0);
        q.delete();
        model_clear();
        @(posedge clk);
        #1;
        check("r036_rst_hold", res_stb_w, 0);
        @(negedge clk);
        rst_n = 1'b1;
        res_rdy = 1'b1;
        send(0, 5, 1);
        check("r036_after_dat", res_dat_w, 5);
        drain();

        // Synchronous clear blocks the beat and wipes the partial sum
        send(1, 50, 0);
        clr = 1'b1; arg_stb = 1'b1; arg_chn = 2'd1; arg_dat = 8'sd3; arg_lst = 1'b1;
        tick(a);
        check("r037_clr_no_accept", a, 0);
        clr = 1'b0; arg_stb = 1'b0; arg_lst = 1'b0;
        send(1, 7, 1);
        check("r037_dat", res_dat_w, 7);
        check("r037_ovf", res_ovf_w, 0);
        drain();

        // Randomized traffic, biased toward extreme values to exercise overflow
        for (int i = 0; i < 600; i++) begin
            arg_stb = ($urandom_range(0, 9) < 7);
            arg_chn = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       arg_dat = 8'sd127;
                1:       arg_dat = -8'sd128;
                default: arg_dat = 8'($urandom);
            endcase
            arg_lst = ($urandom_range(0, 3) == 0);
            res_rdy = ($urandom_range(0, 9) < 6);
            clr     = ($urandom_range(0, 49) == 0);
            tick(a);
        end
        clr = 1'b0;
        drain();
        check("final_queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
